polar_leaf_decoder: RTL
=======================

Name: polar_leaf_decoder

Overview:
- Pipelined, parametrised fast-SC leaf decoder for the polar SC decoder.
- Takes M = 2^LOG_M channel-domain LLRs and an M-bit frozen mask for one leaf node.
- Classifies the node as Rate-0, Rate-1, REP or SPC, makes ML hard decisions, and returns both the codeword bits x (partial sums) and the message bits u.
- Generalises the fixed 2-bit leaf to arbitrary leaf size, and adds valid/ready flow control and an unsupported-mask flag.

Parameters:
- W, 19, LLR width, two's complement.
- LOG_M, 2, log2 of leaf size; legal range 1..4, so M = 2..16.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  leaf input valid.
- in_ready  out  1  block can accept input.
- llr_in  in  M*W  lane i at [i*W +: W].
- frozen_in  in  M  bit i = 1 means u_i is frozen (value 0).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- u_out  out  M  decoded message bits, bit i = u_i.
- x_out  out  M  codeword hard decisions (partial sums), bit i = x_i.
- out_mode  out  2  0 = R0, 1 = R1, 2 = REP, 3 = SPC.
- out_err  out  1  frozen mask unsupported.

Behaviour:
- Reset (async, rst_n = 0): all pipeline valids = 0, out_valid = 0, u_out/x_out/out_mode/out_err = 0. in_ready = 1 from the first cycle after reset release.
- Reset asserted mid-operation discards all in-flight leaves; no output is produced for them.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - On stall all three stages hold; otherwise the pipeline advances every cycle, and bubbles propagate.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput is 1 leaf per cycle.
- Outputs are held stable while out_valid & ~out_ready.
- Stage 1 (register):
  - sign s_i = llr[W-1]; magnitude a_i = |llr_i| as unsigned W bits (-2^(W-1) maps to 2^(W-1), exact).
  - Mode decode, in priority order:
    - all ones -> R0.
    - all zeros -> R1.
    - bits 0..M-2 set and bit M-1 clear -> REP.
    - only bit 0 set -> SPC.
    - otherwise -> err = 1, mode = R0.
  - At M = 2: mask 10 decodes as REP; mask 01 is err.
- Stage 2 (register):
  - REP: signed sum of all LLRs at width W+LOG_M, no overflow possible.
  - SPC: parity p = XOR of s_i; argmin of a_i, ties go to the lowest index.
- Stage 3 (register), x decisions by mode:
  - R0: x = 0.
  - R1: x_i = s_i.
  - REP: all x_i = sign(sum); a sum of 0 gives 0.
  - SPC: x_i = s_i, then x at the argmin index is inverted if p = 1.
- Message bits: u = x·G_M, where G_M = F^{⊗LOG_M}, F = [[1,0],[1,1]], natural order (G self-inverse).
  - M = 2: u0 = x0^x1, u1 = x1.
  - M = 4: u0 = x0^x1^x2^x3, u1 = x1^x3, u2 = x2^x3, u3 = x3.
- Frozen u bits are always 0 by construction; the bench checks this as an invariant.
- err leaves: u_out = 0, x_out = 0, out_err = 1, out_mode = 0.

Test Plan (defaults W=19, M=4; LLR lists are lanes 0..3):
- R1: frozen 0000, LLR [-5,3,-2,7] -> after 3 cycles x=1010 (x0..x3), u=0010 (u0..u3), mode=1, err=0.
- SPC:
  - frozen 1000, LLR [-5,3,2,7] -> parity 1, argmin lane 2, x=1010, u=0010, mode=3.
  - LLR [-5,3,-2,7] -> no flip, same x/u.
  - Tie case LLR [-2,2,3,4] -> flip lane 0, x=0000.
- REP / R0:
  - frozen 1110, LLR [-5,-3,2,-1] (sum -7) -> x=1111, u=0001, mode=2.
  - LLR [-5,3,-2,4] (sum 0) -> x=0000, u=0000.
  - frozen 1111 -> u=0000, mode=0.
- Unsupported and extreme values:
  - frozen 0101 -> out_err=1, u=0000, x=0000.
  - LLR [-262144,1,1,1] with R1 -> x=1000.
  - With M=2 and frozen 10 -> mode=2.
- Backpressure: 5 back-to-back leaves with out_ready low for cycles 4..7 -> in_ready low during the stall, outputs held, no loss or duplication, in-order delivery.
- Reset: assert rst_n low with 2 leaves in flight -> out_valid=0 immediately; after release no stale output appears, and a new leaf emerges 3 cycles after transfer.

Source files
------------

// File: rtl/polar_leaf_decoder.sv
// Pipelined fast-SC leaf decoder: classifies a 2^LOG_M leaf as R0/R1/REP/SPC,
// makes ML hard decisions (x) and maps them back to message bits (u = x*G).
// Three register stages with valid/ready flow control; a stall freezes all stages.

module polar_leaf_lane #(
    parameter int W = 19
) (
    input  logic [W-1:0] llr,
    output logic         sgn,
    output logic [W-1:0] mag
);
    // Unsigned magnitude; the most negative value maps exactly to 2^(W-1).
    assign sgn = llr[W-1];
    assign mag = sgn ? (~llr + 1'b1) : llr;
endmodule

module polar_leaf_decoder #(
    parameter int W     = 19,
    parameter int LOG_M = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [(1<<LOG_M)*W-1:0] llr_in,
    input  logic [(1<<LOG_M)-1:0]   frozen_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [(1<<LOG_M)-1:0]   u_out,
    output logic [(1<<LOG_M)-1:0]   x_out,
    output logic [1:0]           out_mode,
    output logic                 out_err
);
    localparam int M      = 1 << LOG_M;
    localparam int SW     = W + LOG_M;
    localparam int STAGES = 3;
    localparam logic [M-1:0] REP_MASK = {1'b0, {(M-1){1'b1}}};
    localparam logic [M-1:0] SPC_MASK = {{(M-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {MODE_R0 = 2'd0, MODE_R1 = 2'd1, MODE_REP = 2'd2, MODE_SPC = 2'd3} mode_e;

    logic [STAGES:0] vld_pipe;
    logic            stall;

    assign stall       = vld_pipe[STAGES] & ~out_ready;
    assign in_ready    = ~stall;
    assign vld_pipe[0] = in_valid;
    assign out_valid   = vld_pipe[STAGES];

    // ---------------- stage 1: sign/magnitude and mode ----------------
    logic [M-1:0][W-1:0] lanes, mag_c;
    logic [M-1:0]        sgn_c;
    mode_e               mode_c;
    logic                err_c;

    assign lanes = llr_in;

    for (genvar g = 0; g < M; g++) begin : g_lane
        polar_leaf_lane #(.W(W)) u_lane (.llr(lanes[g]), .sgn(sgn_c[g]), .mag(mag_c[g]));
    end

    // Mode decode in priority order; any other mask is flagged and treated as R0.
    always_comb begin
        mode_c = MODE_R0;
        err_c  = 1'b0;
        if (&frozen_in)                  mode_c = MODE_R0;
        else if (~|frozen_in)            mode_c = MODE_R1;
        else if (frozen_in == REP_MASK)  mode_c = MODE_REP;
        else if (frozen_in == SPC_MASK)  mode_c = MODE_SPC;
        else                             err_c  = 1'b1;
    end

    logic [M-1:0][W-1:0] s1_llr, s1_mag;
    logic [M-1:0]        s1_sgn;
    mode_e               s1_mode;
    logic                s1_err;

    // Stage-1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_llr  <= '0;
            s1_mag  <= '0;
            s1_sgn  <= '0;
            s1_mode <= MODE_R0;
            s1_err  <= 1'b0;
        end else if (!stall) begin
            s1_llr  <= lanes;
            s1_mag  <= mag_c;
            s1_sgn  <= sgn_c;
            s1_mode <= mode_c;
            s1_err  <= err_c;
        end
    end

    // ---------------- stage 2: REP sum, SPC parity and argmin ----------------
    logic [SW-1:0]    sum_c;
    logic             par_c;
    logic [LOG_M-1:0] idx_c;
    logic [W-1:0]     min_c;

    // Strict compare keeps the lowest index on magnitude ties.
    always_comb begin
        sum_c = '0;
        par_c = 1'b0;
        idx_c = '0;
        min_c = s1_mag[0];
        for (int i = 0; i < M; i++) begin
            sum_c = sum_c + {{LOG_M{s1_llr[i][W-1]}}, s1_llr[i]};
            par_c = par_c ^ s1_sgn[i];
        end
        for (int i = 1; i < M; i++) begin
            if (s1_mag[i] < min_c) begin
                min_c = s1_mag[i];
                idx_c = LOG_M'(i);
            end
        end
    end

    logic [SW-1:0]    s2_sum;
    logic             s2_par;
    logic [LOG_M-1:0] s2_idx;
    logic [M-1:0]     s2_sgn;
    mode_e            s2_mode;
    logic             s2_err;

    // Stage-2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sum  <= '0;
            s2_par  <= 1'b0;
            s2_idx  <= '0;
            s2_sgn  <= '0;
            s2_mode <= MODE_R0;
            s2_err  <= 1'b0;
        end else if (!stall) begin
            s2_sum  <= sum_c;
            s2_par  <= par_c;
            s2_idx  <= idx_c;
            s2_sgn  <= s1_sgn;
            s2_mode <= s1_mode;
            s2_err  <= s1_err;
        end
    end

    // ---------------- stage 3: hard decisions and u = x*G ----------------
    logic [M-1:0] x_c, u_c;

    // x by mode, then u_i = XOR of x_j over all j whose index bits cover i.
    always_comb begin
        x_c = '0;
        u_c = '0;
        case (s2_mode)
            MODE_R1:  x_c = s2_sgn;
            MODE_REP: x_c = {M{s2_sum[SW-1]}};
            MODE_SPC: begin
                x_c = s2_sgn;
                if (s2_par) x_c[s2_idx] = ~s2_sgn[s2_idx];
            end
            default:  x_c = '0;
        endcase
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                if ((i & ~j) == 0) u_c[i] = u_c[i] ^ x_c[j];
    end

    // Output register and valid shift register; both hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[STAGES:1] <= '0;
            x_out    <= '0;
            u_out    <= '0;
            out_mode <= 2'd0;
            out_err  <= 1'b0;
        end else if (!stall) begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            x_out    <= x_c;
            u_out    <= u_c;
            out_mode <= s2_mode;
            out_err  <= s2_err;
        end
    end
endmodule
